// File: rtl/rv_ctrl_pkg.sv
// Shared control constants for the RV32IM core: opcodes, ALU and MU operation
// codes, and result-mux indices.
package rv_ctrl_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [1:0] MU_MUL    = 2'b00;
    localparam logic [1:0] MU_MULH   = 2'b01;
    localparam logic [1:0] MU_MULHSU = 2'b10;
    localparam logic [1:0] MU_MULHU  = 2'b11;

    localparam int RES_ALU = 0;
    localparam int RES_MU  = 1;

    // Multiply group of the M extension; divides (func3[2]=1) are excluded.
    function automatic logic is_mul_op(input logic [6:0] opcode,
                                       input logic [2:0] func3,
                                       input logic [1:0] func7b50);
        return (opcode == OP) && (func7b50 == 2'b01) && !func3[2];
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from opcode, func3 and func7 bits 5/0.
import rv_ctrl_pkg::*;

module alu_decoder (
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [1:0] func7b50,
    output logic [3:0] aluctl
);

    always_comb begin
        // NOTE: default first so every path assigns aluctl and no latch is inferred.
        aluctl = ALU_ADD;
        case (opcode)
            OP: begin
                // func7b50 == 01 is the M extension; the ALU only forms an address-free ADD.
                if (func7b50 != 2'b01) begin
                    if (func3 == 3'b000 || func3 == 3'b101)
                        aluctl = {func7b50[1], func3};
                    else
                        aluctl = {1'b0, func3};
                end
            end
            OP_IMM: begin
                // bit30 is immediate data for ADDI, so only shifts honour it.
                if (func3 == 3'b101)
                    aluctl = {func7b50[1], func3};
                else
                    aluctl = {1'b0, func3};
            end
            BRANCH: begin
                case (func3[2:1])
                    2'b00:   aluctl = ALU_SUB;
                    2'b10:   aluctl = ALU_SLT;
                    2'b11:   aluctl = ALU_SLTU;
                    default: aluctl = ALU_ADD;
                endcase
            end
            default: aluctl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/ex_control_unit.sv
// Execute-stage control decoder: ALU select, MU select with a one-cycle start
// pulse, and the ALU/MU result-mux select.
import rv_ctrl_pkg::*;

module ex_control_unit #(
    parameter int ifuresctl_N = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [6:0]                     opcode,
    input  logic [2:0]                     func3,
    input  logic [1:0]                     func7b50,
    output logic [3:0]                     aluctl,
    output logic [1:0]                     mulctl,
    output logic                           mulstart,
    output logic [$clog2(ifuresctl_N)-1:0] ifuresctl
);

    localparam int RES_W = $clog2(ifuresctl_N);

    logic is_mul;
    logic mul_seen;

    assign is_mul = is_mul_op(opcode, func3, func7b50);

    alu_decoder u_alu_decoder (
        .opcode   (opcode),
        .func3    (func3),
        .func7b50 (func7b50),
        .aluctl   (aluctl)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            mul_seen <= 1'b0;
        else
            mul_seen <= is_mul;
    end

    // Mealy edge detect: fires on the first cycle the multiply decode appears.
    assign mulstart  = is_mul & ~mul_seen & ~rst;
    assign mulctl    = is_mul ? func3[1:0] : MU_MUL;
    assign ifuresctl = is_mul ? RES_W'(RES_MU) : RES_W'(RES_ALU);

endmodule

// File: tb/tb_ex_control_unit.sv
// Self-checking bench for ex_control_unit: directed table, multi-cycle pulse
// sequences and randomized decode against an instruction-level reference model.
module tb_ex_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [1:0] func7b50;
    logic [3:0] aluctl;
    logic [1:0] mulctl;
    logic       mulstart;
    logic [0:0] ifuresctl;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [1:0] f7;
        logic [3:0] alu;
        logic [1:0] mul;
        logic       res;
    } vec_t;

    typedef struct {
        logic [3:0] alu;
        logic [1:0] mul;
        logic       res;
        logic       is_mul;
    } exp_t;

    vec_t tbl[16];
    exp_t exp_cur;
    logic exp_start;
    logic model_seen = 1'b0;

    always #5 clk = ~clk;

    ex_control_unit #(.ifuresctl_N(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .func3     (func3),
        .func7b50  (func7b50),
        .aluctl    (aluctl),
        .mulctl    (mulctl),
        .mulstart  (mulstart),
        .ifuresctl (ifuresctl)
    );

    // Reference: classify the instruction as the ISA describes it, then name its ALU operation.
    function automatic exp_t ref_model(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [1:0] f7);
        exp_t e;
        logic [3:0] base_op[8];
        base_op[0] = 4'b0000; base_op[1] = 4'b0001; base_op[2] = 4'b0010; base_op[3] = 4'b0011;
        base_op[4] = 4'b0100; base_op[5] = 4'b0101; base_op[6] = 4'b0110; base_op[7] = 4'b0111;
        e.alu = 4'b0000;
        e.mul = 2'b00;
        e.res = 1'b0;
        e.is_mul = 1'b0;
        if (op == 7'b0110011 && f7 == 2'b01) begin
            if (f3 < 3'd4) begin
                e.is_mul = 1'b1;
                e.mul = f3[1:0];
                e.res = 1'b1;
            end
        end else if (op == 7'b0110011) begin
            if (f3 == 3'd0)      e.alu = f7[1] ? 4'b1000 : 4'b0000;
            else if (f3 == 3'd5) e.alu = f7[1] ? 4'b1101 : 4'b0101;
            else                 e.alu = base_op[f3];
        end else if (op == 7'b0010011) begin
            if (f3 == 3'd5) e.alu = f7[1] ? 4'b1101 : 4'b0101;
            else            e.alu = base_op[f3];
        end else if (op == 7'b1100011) begin
            if (f3 == 3'd0 || f3 == 3'd1)      e.alu = 4'b1000;
            else if (f3 == 3'd4 || f3 == 3'd5) e.alu = 4'b0010;
            else if (f3 == 3'd6 || f3 == 3'd7) e.alu = 4'b0011;
            else                               e.alu = 4'b0000;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs away from the rising edge, then advance the pulse model.
    task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] f7,
                        input logic r);
        @(negedge clk);
        opcode   = op;
        func3    = f3;
        func7b50 = f7;
        rst      = r;
        #1;
        exp_cur   = ref_model(op, f3, f7);
        exp_start = exp_cur.is_mul && !model_seen && !r;
        model_seen = r ? 1'b0 : exp_cur.is_mul;
    endtask

    task automatic check_all(input string tag);
        check({tag, " aluctl"},    32'(aluctl),    32'(exp_cur.alu));
        check({tag, " mulctl"},    32'(mulctl),    32'(exp_cur.mul));
        check({tag, " ifuresctl"}, 32'(ifuresctl), 32'(exp_cur.res));
        check({tag, " mulstart"},  32'(mulstart),  32'(exp_start));
    endtask

    initial begin
        logic [6:0] ops[10];
        rst = 1'b1; opcode = 7'b0010011; func3 = 3'b000; func7b50 = 2'b00;

        tbl[0]  = '{7'b0110011, 3'b000, 2'b00, 4'b0000, 2'b00, 1'b0};
        tbl[1]  = '{7'b0110011, 3'b000, 2'b10, 4'b1000, 2'b00, 1'b0};
        tbl[2]  = '{7'b0110011, 3'b101, 2'b10, 4'b1101, 2'b00, 1'b0};
        tbl[3]  = '{7'b0010011, 3'b000, 2'b10, 4'b0000, 2'b00, 1'b0};
        tbl[4]  = '{7'b0010011, 3'b101, 2'b10, 4'b1101, 2'b00, 1'b0};
        tbl[5]  = '{7'b1100011, 3'b001, 2'b00, 4'b1000, 2'b00, 1'b0};
        tbl[6]  = '{7'b1100011, 3'b100, 2'b00, 4'b0010, 2'b00, 1'b0};
        tbl[7]  = '{7'b1100011, 3'b111, 2'b00, 4'b0011, 2'b00, 1'b0};
        tbl[8]  = '{7'b0000011, 3'b010, 2'b00, 4'b0000, 2'b00, 1'b0};
        tbl[9]  = '{7'b0110011, 3'b100, 2'b01, 4'b0000, 2'b00, 1'b0};
        tbl[10] = '{7'b0110011, 3'b011, 2'b01, 4'b0000, 2'b11, 1'b1};
        tbl[11] = '{7'b0110011, 3'b000, 2'b11, 4'b1000, 2'b00, 1'b0};
        tbl[12] = '{7'b0110011, 3'b110, 2'b11, 4'b0110, 2'b00, 1'b0};
        tbl[13] = '{7'b0010011, 3'b011, 2'b00, 4'b0011, 2'b00, 1'b0};
        tbl[14] = '{7'b0110011, 3'b001, 2'b00, 4'b0001, 2'b00, 1'b0};
        tbl[15] = '{7'b1100011, 3'b010, 2'b00, 4'b0000, 2'b00, 1'b0};

        // Reset held with MUL presented: no pulse, decode still live.
        step(7'b0110011, 3'b000, 2'b01, 1'b1);
        check("reset mulstart", 32'(mulstart), 32'd0);
        check("reset ifuresctl", 32'(ifuresctl), 32'd1);
        step(7'b0010011, 3'b000, 2'b00, 1'b1);
        check("reset idle mulstart", 32'(mulstart), 32'd0);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].op, tbl[i].f3, tbl[i].f7, 1'b0);
            check($sformatf("tbl%0d aluctl", i),    32'(aluctl),    32'(tbl[i].alu));
            check($sformatf("tbl%0d mulctl", i),    32'(mulctl),    32'(tbl[i].mul));
            check($sformatf("tbl%0d ifuresctl", i), 32'(ifuresctl), 32'(tbl[i].res));
            check($sformatf("tbl%0d mulstart", i),  32'(mulstart),  32'(exp_start));
        end

        // ADDI, then MULHU held three cycles, then ADDI, then MUL.
        step(7'b0010011, 3'b000, 2'b00, 1'b0);
        check("seq addi mulstart", 32'(mulstart), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            step(7'b0110011, 3'b011, 2'b01, 1'b0);
            check($sformatf("mulhu c%0d mulctl", c),    32'(mulctl),    32'd3);
            check($sformatf("mulhu c%0d ifuresctl", c), 32'(ifuresctl), 32'd1);
            check($sformatf("mulhu c%0d mulstart", c),  32'(mulstart),  (c == 1) ? 32'd1 : 32'd0);
        end
        step(7'b0010011, 3'b000, 2'b00, 1'b0);
        check("seq addi2 mulstart", 32'(mulstart), 32'd0);
        step(7'b0110011, 3'b000, 2'b01, 1'b0);
        check("seq mul mulstart", 32'(mulstart), 32'd1);
        step(7'b0110011, 3'b000, 2'b01, 1'b0);
        check("seq mul hold mulstart", 32'(mulstart), 32'd0);

        // One-cycle reset while MUL is held re-arms exactly one pulse.
        step(7'b0110011, 3'b000, 2'b01, 1'b1);
        check("midrst during mulstart", 32'(mulstart), 32'd0);
        step(7'b0110011, 3'b000, 2'b01, 1'b0);
        check("midrst after mulstart", 32'(mulstart), 32'd1);
        step(7'b0110011, 3'b000, 2'b01, 1'b0);
        check("midrst hold mulstart", 32'(mulstart), 32'd0);
        step(7'b0110011, 3'b000, 2'b01, 1'b0);
        check("midrst hold2 mulstart", 32'(mulstart), 32'd0);

        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b1100011; ops[3] = 7'b0000011;
        ops[4] = 7'b0100011; ops[5] = 7'b1101111; ops[6] = 7'b1100111; ops[7] = 7'b0110111;
        ops[8] = 7'b0010111; ops[9] = 7'b0110011;
        for (int i = 0; i < 400; i++) begin
            logic [6:0] op;
            logic [1:0] f7;
            int sel;
            sel = int'($urandom_range(0, 11));
            op = (sel < 10) ? ops[sel] : 7'($urandom);
            f7 = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'($urandom);
            step(op, 3'($urandom), f7, $urandom_range(0, 19) == 0);
            check_all($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_control_unit.md
Name: ex_control_unit

Overview:
- Execute-stage control decoder for the multi-cycle RV32IM core; instantiated inside the main controller FSM.
- Decodes opcode/func3/func7 bits into three control groups:
  - ALU operation select.
  - Multiplier-unit (MU) operation select and start pulse.
  - Result-mux select between ALU and MU.
- ALU/MU/mux selects are combinational and valid in the same cycle the instruction fields are presented. The MU start is a single-cycle pulse generated with one state bit.

Parameters:
- ifuresctl_N, 2, number of inputs on the IFU result mux; index 0 = ALU, 1 = MU; must be >= 2.

Ports:
- clk  input  1  core clock; the single state bit updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  7  instruction[6:0].
- func3  input  3  instruction[14:12].
- func7b50  input  2  {instruction[30], instruction[25]}, i.e. func7 bit5 in [1] and func7 bit0 in [0].
- aluctl  output  4  ALU operation code.
- mulctl  output  2  MU operation code.
- mulstart  output  1  one-cycle MU start pulse.
- ifuresctl  output  $clog2(ifuresctl_N)  result mux select.

Behaviour:
- One clock domain. Reset is synchronous and active-high; the reset port is named rst.
- ALU code encoding (aluctl): ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- Internal decode is_mul = (opcode==7'b0110011) && (func7b50==2'b01) && (func3[2]==0).
- OP (7'b0110011) with func7b50[0]=0:
  - aluctl = {func7b50[1], func3} when func3 is 000 or 101.
  - Otherwise aluctl = {1'b0, func3}.
- OP-IMM (7'b0010011):
  - aluctl = {func7b50[1], func3} only when func3==101 (SRLI/SRAI).
  - Otherwise aluctl = {1'b0, func3}; ADDI never subtracts.
- BRANCH (7'b1100011):
  - func3 000/001 -> SUB.
  - func3 100/101 -> SLT.
  - func3 110/111 -> SLTU.
  - 010/011 -> ADD.
- LOAD, STORE, JAL, JALR, LUI, AUIPC, and any undefined opcode -> aluctl = ADD (0000).
- M-extension multiply (is_mul):
  - mulctl = func3[1:0], giving MUL 00, MULH 01, MULHSU 10, MULHU 11.
  - ifuresctl = 1.
  - aluctl = ADD.
- M-extension divide (OP, func7b50==01, func3[2]=1) is unsupported:
  - aluctl = ADD, mulctl = 00, ifuresctl = 0, and no mulstart.
- Any instruction that is not is_mul: mulctl = 00, ifuresctl = 0.
- func7b50 == 2'b11 on OP is illegal and is decoded as the base ALU case, using func7b50[1].
- mulstart, Mealy pulse:
  - Internal register mul_seen <= is_mul on every clock edge; rst clears it to 0.
  - mulstart = is_mul & ~mul_seen & ~rst.
  - Result: high for exactly the first cycle an MU instruction is presented, low while the same decode is held.
  - Two back-to-back MU instructions with no intervening non-MU cycle produce only one pulse. The upstream FSM guarantees a non-MU/IF cycle between instructions.
- Reset values:
  - While rst is high, mulstart = 0 and mul_seen = 0 after the edge.
  - aluctl, mulctl and ifuresctl are pure decode and are unaffected by rst.
- Reset mid-multiply: mul_seen clears. If is_mul is still presented after rst deasserts, one new mulstart pulse is issued.
- No X propagation: every output is fully assigned on all paths (default branches included).

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - Opcode constants OP, OP_IMM, BRANCH, LOAD, STORE, JAL, JALR, LUI, AUIPC.
  - ALU code localparams ALU_ADD..ALU_AND.
  - MU codes MU_MUL, MU_MULH, MU_MULHSU, MU_MULHU.
  - Mux indices RES_ALU=0, RES_MU=1.
- One natural sub-module, alu_decoder: combinational opcode/func3/func7b5 -> aluctl.
- The MU decode and the mulstart edge logic stay in the top level.

Test Plan:
- ADD vs SUB vs SRA: opcode 0110011 with
  - func3 000, func7b50 00 -> aluctl 0000
  - func3 000, func7b50 10 -> aluctl 1000
  - func3 101, func7b50 10 -> aluctl 1101
  - In all three cases ifuresctl 0 and mulstart 0.
- ADDI with bit30 set: opcode 0010011, func3 000, func7b50 10 -> aluctl 0000. SRAI (func3 101, func7b50 10) -> aluctl 1101.
- Branches: opcode 1100011 with func3 001 -> 1000, func3 100 -> 0010, func3 111 -> 0011. LW (0000011) -> 0000.
- MULHU held 3 cycles after an ADDI cycle: opcode 0110011, func3 011, func7b50 01.
  - mulctl 11 and ifuresctl 1 throughout.
  - mulstart = 1 in cycle 1, 0 in cycles 2-3.
  - Returning to ADDI then MUL gives a new single pulse.
- DIV (func3 100, func7b50 01) -> mulstart 0, ifuresctl 0, aluctl 0000, mulctl 00.
- rst asserted for one cycle while MUL is held:
  - mulstart 0 during rst.
  - mulstart = 1 in the first cycle after rst deasserts.
  - 0 thereafter.
